controller: RTL and testbench

//  Top-level tile scheduler for the conv accelerator. Latches layer geometry on start, derives per-tile

---
 rtl/controller.sv | 216 +++++++++++++++++++++
 tb/tb_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Tile scheduler for the conv accelerator: latches layer geometry, derives
// per-tile latency with a serial divider, queues tiles and dispatches them
// round-robin to a set of modelled cores, then reports busy/done.
module controller #(
  parameter int NUM_CORES  = 2,
  parameter int POF        = 2,
  parameter int PIF        = 3,
  parameter int MULT_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tile_valid,
  input  logic                            is_dfconv,
  input  logic [15:0]                     rows,
  input  logic [15:0]                     cols,
  input  logic [15:0]                     in_ch,
  input  logic [15:0]                     out_ch,
  input  logic [POF*PIF*MULT_WIDTH-1:0]   assigned_mults_flat,
  input  logic                            start,
  output logic                            busy,
  output logic                            done
);

  localparam int NF     = POF * PIF;
  localparam int SUM_W  = MULT_WIDTH + $clog2(NF + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RUN, FINISH} state_t;

  state_t                  state, state_nxt;
  logic [15:0]             rows_l, cols_l, in_ch_l, out_ch_l;
  logic [NF*MULT_WIDTH-1:0] mults_l;
  logic [63:0]             macs;
  logic [63:0]             quo;
  logic [SUM_W-1:0]        rem, div;
  logic [SUM_W:0]          rem_sh, rem_x2;
  logic [SUM_W-1:0]        rem_diff;
  logic                    rem_ge;
  logic [6:0]              step;
  logic [1:0]              dfc_extra;
  logic [65:0]             sftm_raw, dfc_raw;
  logic [31:0]             sftm_cyc, dfconv_cyc;
  logic [FIFO_DEPTH-1:0]   fifo_mem;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [PTR_W:0]          fifo_cnt;
  logic                    empty, full, push, pop;
  logic [31:0]             tile_cnt;
  logic [31:0]             core_cnt [NUM_CORES];
  logic [CORE_W-1:0]       rr, sel;
  logic                    any_idle, all_idle;
  int                      idx;

  // Total multiplier allocation; an all-zero allocation counts as one.
  function automatic logic [SUM_W-1:0] mult_sum(input logic [NF*MULT_WIDTH-1:0] f);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < NF; k++) s = s + SUM_W'(f[k*MULT_WIDTH +: MULT_WIDTH]);
    if (s == '0) s = SUM_W'(1);
    return s;
  endfunction

  // Clamp a cycle count to [1, 2^32-1].
  function automatic logic [31:0] sat_cyc(input logic [65:0] v);
    if (v == '0) return 32'd1;
    if (v > 66'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
    return v[31:0];
  endfunction

  assign macs     = 64'(rows_l) * 64'(cols_l) * 64'(in_ch_l) * 64'(out_ch_l);
  assign rem_sh   = {rem, quo[63]};
  assign rem_ge   = rem_sh >= {1'b0, div};
  assign rem_diff = SUM_W'(rem_sh - {1'b0, div});
  assign rem_x2   = {rem, 1'b0};
  assign empty    = (fifo_cnt == '0);
  assign full     = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = (state == RUN) && !empty && any_idle;
  assign push     = ((state == CALC) || (state == RUN)) && tile_valid && (!full || pop);

  // Layer geometry captured on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      rows_l   <= rows;
      cols_l   <= cols;
      in_ch_l  <= in_ch;
      out_ch_l <= out_ch;
      mults_l  <= assigned_mults_flat;
    end
  end

  // Restoring divider: load on the first CALC cycle, then one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (state == CALC) begin
      if (step == '0) begin
        quo <= macs;
        rem <= '0;
        div <= mult_sum(mults_l);
      end else begin
        quo <= {quo[62:0], rem_ge};
        rem <= rem_ge ? rem_diff : rem_sh[SUM_W-1:0];
      end
    end
  end

  // Ceiling quotients for both tile types from the final quotient/remainder.
  // ceil(2m/T) = 2q + (r==0 ? 0 : 2r<=T ? 1 : 2), so one division serves both.
  always_comb begin
    dfc_extra = 2'd0;
    if (rem != '0) dfc_extra = (rem_x2 <= {1'b0, div}) ? 2'd1 : 2'd2;
    sftm_raw   = {2'b00, quo} + {65'd0, (rem != '0)};
    dfc_raw    = {1'b0, quo, 1'b0} + {64'd0, dfc_extra};
    sftm_cyc   = sat_cyc(sftm_raw);
    dfconv_cyc = sat_cyc(dfc_raw);
  end

  // Divider step counter, runs only while in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             step <= '0;
    else if (state == CALC) step <= step + 7'd1;
    else                    step <= '0;
  end

  // Pending-tile storage; entries hold only the tile type.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= is_dfconv;
  end

  // Queue pointers, occupancy and accepted-tile count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      tile_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
        tile_cnt <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        tile_cnt <= tile_cnt + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Find the first idle core at or after the round-robin pointer.
  always_comb begin
    any_idle = 1'b0;
    all_idle = 1'b1;
    sel      = '0;
    idx      = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(rr) + i) % NUM_CORES;
      if (!any_idle && core_cnt[idx] == '0) begin
        any_idle = 1'b1;
        sel      = CORE_W'(idx);
      end
      if (core_cnt[i] != '0) all_idle = 1'b0;
    end
  end

  // Core down-counters and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
      for (int c = 0; c < NUM_CORES; c++) core_cnt[c] <= '0;
    end else begin
      if (pop) rr <= (int'(sel) == NUM_CORES - 1) ? '0 : sel + 1'b1;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (pop && int'(sel) == c)  core_cnt[c] <= fifo_mem[rd_ptr] ? dfconv_cyc : sftm_cyc;
        else if (core_cnt[c] != '0) core_cnt[c] <= core_cnt[c] - 32'd1;
      end
    end
  end

  // Layer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (step == 7'd64) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (tile_cnt != '0 && empty && all_idle && !tile_valid) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done rises with FINISH and holds until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              done <= 1'b0;
    else if (state == IDLE && start)         done <= 1'b0;
    else if (state == RUN && state_nxt == FINISH) done <= 1'b1;
  end

endmodule

// File: tb/tb_controller.sv
// Bench for the tile scheduler: layers of random and directed tiles checked
// against a list-scheduling model of queue, divider latency and cores.
module tb_controller;

  localparam int NUM_CORES = 2;
  localparam int POF       = 2;
  localparam int PIF       = 3;
  localparam int MW        = 16;
  localparam int FD        = 8;
  localparam int CALC_LAT  = 67;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tile_valid = 1'b0;
  logic is_dfconv = 1'b0;
  logic start = 1'b0;
  logic [15:0] rows = '0, cols = '0, in_ch = '0, out_ch = '0;
  logic [POF*PIF*MW-1:0] mults = '0;
  logic busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  controller #(
    .NUM_CORES(NUM_CORES), .POF(POF), .PIF(PIF), .MULT_WIDTH(MW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .is_dfconv(is_dfconv),
    .rows(rows), .cols(cols), .in_ch(in_ch), .out_ch(out_ch),
    .assigned_mults_flat(mults), .start(start), .busy(busy), .done(done)
  );

  function automatic longint ceil_div(input longint a, input longint b);
    return (a + b - 1) / b;
  endfunction

  // Makespan in RUN cycles: tiles beyond the queue depth are lost, the rest
  // are handed one per cycle to the first free core from the rotating pointer.
  function automatic int model_m(input int r, input int c, input int ic, input int oc,
                                 input logic [POF*PIF*MW-1:0] mf, input int n,
                                 input logic [15:0] ty);
    longint macs, t, s, d;
    int free_at [NUM_CORES];
    int rr, tt, acc, csel, dur, m, id;
    t = 0;
    for (int k = 0; k < POF*PIF; k++) t += longint'(mf[k*MW +: MW]);
    if (t == 0) t = 1;
    macs = longint'(r) * c * ic * oc;
    s = ceil_div(macs, t); if (s < 1) s = 1;
    d = ceil_div(2 * macs, t); if (d < 1) d = 1;
    acc = (n > FD) ? FD : n;
    for (int k = 0; k < NUM_CORES; k++) free_at[k] = 0;
    rr = 0; tt = -1; m = 0;
    for (int i = 0; i < acc; i++) begin
      tt++;
      csel = -1;
      while (csel < 0) begin
        for (int j = 0; j < NUM_CORES; j++) begin
          id = (rr + j) % NUM_CORES;
          if (csel < 0 && free_at[id] <= tt) csel = id;
        end
        if (csel < 0) tt++;
      end
      dur = ty[i] ? int'(d) : int'(s);
      free_at[csel] = tt + dur + 1;
      rr = (csel + 1) % NUM_CORES;
      if (tt + dur > m) m = tt + dur;
    end
    return m;
  endfunction

  // Start a layer, stream n tiles, then count cycles from the start edge until done.
  task automatic run_layer(input logic [15:0] r, input logic [15:0] c, input logic [15:0] ic,
                           input logic [15:0] oc, input logic [POF*PIF*MW-1:0] mf,
                           input int n, input logic [15:0] ty, input int max_cyc,
                           input int poke_at, output int cyc, output bit to,
                           output logic b1, output logic d1, output logic bdone);
    @(negedge clk);
    rows = r; cols = c; in_ch = ic; out_ch = oc; mults = mf;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    b1 = busy; d1 = done;
    to = 1'b1; bdone = 1'bx;
    while (cyc < max_cyc) begin
      if (cyc < n) begin tile_valid = 1'b1; is_dfconv = ty[cyc]; end
      else         begin tile_valid = 1'b0; is_dfconv = 1'b0; end
      start = (poke_at > 0 && cyc == poke_at);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin to = 1'b0; bdone = busy; break; end
    end
    tile_valid = 1'b0; is_dfconv = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold busy=%b done=%b required 0/0", busy, done);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_release busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc, m; bit to; logic b1, d1, bd;
    m = model_m(4, 4, 16, 16, 96'd64, 6, 16'b110000);
    run_layer(4, 4, 16, 16, 96'd64, 6, 16'b110000, m + 200, 0, cyc, to, b1, d1, bd);
    n_checks++;
    if (b1 !== 1'b1 || d1 !== 1'b0) begin
      n_fail++; $display("FAIL basic_calc busy=%b done=%b required 1/0", b1, d1);
    end
    n_checks++;
    if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2) begin
      n_fail++; $display("FAIL basic_latency got=%0d timeout=%0d required=%0d", cyc, to, m + CALC_LAT);
    end
    n_checks++;
    if (bd !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_at_done busy=%b required 0", bd);
    end
  endtask

  task automatic test_zero_alloc();
    int cyc, m; bit to; logic b1, d1, bd;
    m = model_m(1, 1, 1, 1, 96'd0, 1, 16'b0);
    run_layer(1, 1, 1, 1, 96'd0, 1, 16'b0, 150, 0, cyc, to, b1, d1, bd);
    n_checks++;
    if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2) begin
      n_fail++; $display("FAIL zero_alloc_latency got=%0d timeout=%0d required=%0d", cyc, to, m + CALC_LAT);
    end
    n_checks++;
    if (bd !== 1'b0) begin
      n_fail++; $display("FAIL zero_alloc_busy busy=%b required 0", bd);
    end
  endtask

  task automatic test_overflow();
    int cyc, m; bit to; logic b1, d1, bd;
    m = model_m(4, 4, 16, 16, 96'd64, 10, 16'b0);
    run_layer(4, 4, 16, 16, 96'd64, 10, 16'b0, m + 300, 0, cyc, to, b1, d1, bd);
    n_checks++;
    if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2) begin
      n_fail++; $display("FAIL overflow_latency got=%0d timeout=%0d required=%0d", cyc, to, m + CALC_LAT);
    end
  endtask

  task automatic test_start_ignored_done_hold();
    int cyc, m; bit to; logic b1, d1, bd;
    m = model_m(4, 4, 16, 16, 96'd64, 6, 16'b110000);
    run_layer(4, 4, 16, 16, 96'd64, 6, 16'b110000, m + 200, 150, cyc, to, b1, d1, bd);
    n_checks++;
    if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2) begin
      n_fail++; $display("FAIL busy_start_latency got=%0d timeout=%0d required=%0d", cyc, to, m + CALC_LAT);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL done_hold cycle=%0d done=%b busy=%b required 1/0", i, done, busy);
      end
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart done=%b busy=%b required 0/1", done, busy);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_run();
    int cyc, m; bit to; logic b1, d1, bd;
    run_layer(4, 4, 16, 16, 96'd64, 6, 16'b110000, 120, 0, cyc, to, b1, d1, bd);
    n_checks++;
    if (to !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_busy busy=%b timeout=%0d required 1/1", busy, to);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset busy=%b done=%b required 0/0", busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m = model_m(4, 4, 16, 16, 96'd64, 6, 16'b110000);
    run_layer(4, 4, 16, 16, 96'd64, 6, 16'b110000, m + 200, 0, cyc, to, b1, d1, bd);
    n_checks++;
    if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2 || bd !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_latency got=%0d timeout=%0d busy=%b required=%0d", cyc, to, bd, m + CALC_LAT);
    end
  endtask

  task automatic test_random();
    int cyc, m, n, r, c, ic, oc; bit to; logic b1, d1, bd;
    logic [POF*PIF*MW-1:0] mf;
    logic [15:0] ty;
    for (int it = 0; it < 6; it++) begin
      r = $urandom_range(1, 4); c = $urandom_range(1, 4);
      ic = $urandom_range(1, 8); oc = $urandom_range(1, 8);
      mf = '0;
      for (int k = 0; k < POF*PIF; k++) mf[k*MW +: MW] = 16'($urandom_range(4, 40));
      n = $urandom_range(1, 10);
      ty = 16'($urandom);
      m = model_m(r, c, ic, oc, mf, n, ty);
      run_layer(16'(r), 16'(c), 16'(ic), 16'(oc), mf, n, ty, m + 300, 0, cyc, to, b1, d1, bd);
      n_checks++;
      if (to || cyc < m + CALC_LAT - 2 || cyc > m + CALC_LAT + 2 || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d got=%0d timeout=%0d busy=%b required=%0d", it, cyc, to, bd, m + CALC_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_alloc();
    test_overflow();
    test_start_ignored_done_hold();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
